// File: rtl/util_clk_pkg.sv
// Shared definitions for the ext-clock monitor/supervisor blocks.
// State encodings and a constant-width helper.
package util_clk_pkg;

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_OK   = 2'd1;
  localparam logic [1:0] S_LOST = 2'd2;

  // Bits needed to hold values 0..v-1 (never less than 1).
  function automatic int clog2(input longint v);
    int r;
    r = 0;
    while ((64'd1 << r) < v) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/util_sync_bit.sv
// Multi-flop synchroniser for a single async bit.
// Flops reset to 0 with the block reset.
module util_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the async input through the flop chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= '0;
    else       r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/util_clk_status_supervisor.sv
// Qualifies the monitor's in-range flag into clk_ok with
// lock/loss pulses, loss counter, sticky irq and timeout.
module util_clk_status_supervisor
  import util_clk_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int GOOD_CYCLES    = 1024,
  parameter int BAD_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 mon_state,
  input  logic                 irq_clr,
  input  logic                 cnt_clr,
  output logic                 clk_ok,
  output logic                 lock_pulse,
  output logic                 loss_pulse,
  output logic                 irq,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] loss_count
);

  localparam int RUN_MAX =
    (GOOD_CYCLES > BAD_CYCLES) ? GOOD_CYCLES : BAD_CYCLES;
  localparam int RUN_W = clog2(RUN_MAX + 1);
  localparam int TMO_W = clog2(TIMEOUT_CYCLES + 1);

  localparam logic [RUN_W-1:0] GOOD_N = RUN_W'(GOOD_CYCLES);
  localparam logic [RUN_W-1:0] BAD_N  = RUN_W'(BAD_CYCLES);
  localparam logic [TMO_W-1:0] TMO_N  = TMO_W'(TIMEOUT_CYCLES);

  logic                 w_sync;
  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic [RUN_W-1:0]     r_run_cnt;
  logic [RUN_W-1:0]     w_run_nxt;
  logic [RUN_W-1:0]     w_need;
  logic                 w_target;
  logic                 w_match;
  logic                 w_fire;
  logic                 w_lock_evt;
  logic                 w_loss_evt;
  logic                 w_ok_nxt;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic                 w_tmo_evt;
  logic [CNT_WIDTH-1:0] w_cnt_base;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  util_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (mon_state),
    .o_q  (w_sync)
  );

  // Debounce: count consecutive samples at the level that
  // would move the FSM; fire on the Nth and restart.
  always_comb begin
    w_target  = (r_state != S_OK);
    w_need    = (r_state == S_OK) ? BAD_N : GOOD_N;
    w_match   = (w_sync == w_target);
    w_fire    = w_match && (r_run_cnt == w_need - 1'b1);
    w_run_nxt = '0;
    if (w_match && !w_fire) w_run_nxt = r_run_cnt + 1'b1;
  end

  // Debounce run counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_run_cnt <= '0;
    else       r_run_cnt <= w_run_nxt;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_WAIT;
    else       r_state <= w_next;
  end

  // FSM next-state logic; the unused code recovers to WAIT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_WAIT,
      S_LOST:  if (w_fire) w_next = S_OK;
      S_OK:    if (w_fire) w_next = S_LOST;
      default: w_next = S_WAIT;
    endcase
  end

  // FSM output decode: events on state transitions.
  always_comb begin
    w_ok_nxt   = (w_next == S_OK);
    w_lock_evt = w_ok_nxt && (r_state != S_OK);
    w_loss_evt = (r_state == S_OK) && (w_next == S_LOST);
  end

  // Register the qualifier and event pulses with the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_ok     <= 1'b0;
      lock_pulse <= 1'b0;
      loss_pulse <= 1'b0;
    end else begin
      clk_ok     <= w_ok_nxt;
      lock_pulse <= w_lock_evt;
      loss_pulse <= w_loss_evt;
    end
  end

  // Loss count: clear first, then saturating increment.
  always_comb begin
    w_cnt_base = cnt_clr ? '0 : loss_count;
    w_cnt_nxt  = w_cnt_base;
    if (w_loss_evt && !(&w_cnt_base))
      w_cnt_nxt = w_cnt_base + 1'b1;
  end

  // Sticky irq (a new loss beats a clear) and loss count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq        <= 1'b0;
      loss_count <= '0;
    end else begin
      loss_count <= w_cnt_nxt;
      if (w_loss_evt)   irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

  assign w_tmo_evt = (r_state == S_WAIT) &&
                     (r_tmo_cnt == TMO_N - 1'b1);

  // WAIT-only timeout window; counter parks at the limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      if (r_state == S_WAIT && r_tmo_cnt != TMO_N)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_tmo_evt)    timeout <= 1'b1;
      else if (cnt_clr) timeout <= 1'b0;
    end
  end

endmodule
